// File: rtl/ramp_pkg.sv
// Shared definitions for the ramp pattern generator and checker:
// sample width, step codes and the legal step values behind each code.
package ramp_pkg;

    localparam int RAMP_W = 12;

    typedef logic [RAMP_W-1:0] ramp_t;

    // Step codes carried on Y / det_Y
    typedef enum logic [1:0] {
        Y0    = 2'b00,
        Y1    = 2'b01,
        Y16   = 2'b10,
        Y1290 = 2'b11
    } y_code_e;

    // Step value (deltaY) selected by each code
    localparam ramp_t DELTA_Y0    = ramp_t'(0);
    localparam ramp_t DELTA_Y1    = ramp_t'(1);
    localparam ramp_t DELTA_Y16   = ramp_t'(16);
    localparam ramp_t DELTA_Y1290 = ramp_t'(1290);

    // Checker tracking states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ACQUIRE = 2'b01,
        ST_TRACK   = 2'b10
    } chk_state_e;

endpackage

// File: rtl/ramp_step_decode.sv
// Computes the modulo-4096 step between two ramp samples and classifies it
// against the legal step set. Purely combinational.
module ramp_step_decode
    import ramp_pkg::*;
(
    input  logic [RAMP_W-1:0] smp,
    input  logic [RAMP_W-1:0] prev,
    output logic              legal,
    output logic [1:0]        code
);

    ramp_t step;

    // Unsigned subtraction in RAMP_W bits gives the wrapped step directly
    assign step = smp - prev;

    // Map the step onto its code; anything outside the set is illegal
    always_comb begin
        // NOTE: outputs get defaults before the case so no path leaves them unassigned (no latch).
        legal = 1'b1;
        code  = Y0;
        case (step)
            DELTA_Y0:    code = Y0;
            DELTA_Y1:    code = Y1;
            DELTA_Y16:   code = Y16;
            DELTA_Y1290: code = Y1290;
            default: begin
                legal = 1'b0;
                code  = Y0;
            end
        endcase
    end

endmodule

// File: rtl/ramp_checker.sv
// Receive-side ramp checker: checks each sampled step against the step
// selected by Y, acquires/tracks lock, pulses err on mismatches and keeps
// a saturating error count plus the last detected step code.
module ramp_checker
    import ramp_pkg::*;
#(
    parameter int LOCK_CNT  = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 chk_enb,
    input  logic                 smp_vld,
    input  logic [RAMP_W-1:0]    smp,
    input  logic [1:0]           Y,
    input  logic                 clr_cnt,
    output logic                 locked,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [1:0]           det_Y,
    output logic                 det_vld
);

    chk_state_e state;
    ramp_t      prev;
    logic [3:0] good_cnt;
    logic [1:0] y_q;

    logic       step_legal;
    logic [1:0] step_code;

    ramp_step_decode u_decode (
        .smp   (smp),
        .prev  (prev),
        .legal (step_legal),
        .code  (step_code)
    );

    // A Y change restarts acquisition; a same-cycle sample still counts
    logic                 y_changed;
    logic                 checked;
    logic                 good;
    logic [3:0]           cnt_base;
    logic [4:0]           cnt_next;
    logic                 reach_lock;
    logic [ERR_CNT_W-1:0] err_cnt_inc;

    assign y_changed   = (Y != y_q);
    assign checked     = chk_enb && smp_vld;
    assign good        = step_legal && (step_code == Y);
    assign cnt_base    = y_changed ? 4'd0 : good_cnt;
    assign cnt_next    = {1'b0, cnt_base} + 5'd1;
    assign reach_lock  = (cnt_next >= 5'(LOCK_CNT));
    assign err_cnt_inc = (&err_cnt) ? err_cnt : err_cnt + ERR_CNT_W'(1);

    // Tracking FSM with all outputs, prev, good_cnt and err_cnt registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            prev     <= '0;
            good_cnt <= '0;
            y_q      <= Y0;
            locked   <= 1'b0;
            err      <= 1'b0;
            err_cnt  <= '0;
            det_Y    <= Y0;
            det_vld  <= 1'b0;
        end else begin
            // NOTE: state is updated with <= so every read here sees the pre-edge value.
            y_q <= Y;
            err <= 1'b0;

            // Error counter: a bad step with clr_cnt restarts the count at one
            if (checked && !good) begin
                err_cnt <= clr_cnt ? ERR_CNT_W'(1) : err_cnt_inc;
            end else if (clr_cnt) begin
                err_cnt <= '0;
            end

            if (!chk_enb) begin
                state    <= ST_IDLE;
                prev     <= '0;
                good_cnt <= '0;
                locked   <= 1'b0;
                det_vld  <= 1'b0;
            end else if (smp_vld) begin
                prev <= smp;

                if (step_legal) begin
                    det_Y   <= step_code;
                    det_vld <= 1'b1;
                end else begin
                    det_vld <= 1'b0;
                end

                if (good) begin
                    if (reach_lock) begin
                        state    <= ST_TRACK;
                        locked   <= 1'b1;
                        good_cnt <= 4'(LOCK_CNT);
                    end else begin
                        state    <= ST_ACQUIRE;
                        locked   <= 1'b0;
                        good_cnt <= cnt_next[3:0];
                    end
                end else begin
                    err      <= 1'b1;
                    state    <= ST_ACQUIRE;
                    locked   <= 1'b0;
                    good_cnt <= '0;
                end
            end else if (y_changed || state == ST_IDLE) begin
                state    <= ST_ACQUIRE;
                locked   <= 1'b0;
                good_cnt <= '0;
            end
        end
    end

endmodule
